// File: rtl/oam_dma_ctrl_if.sv
`default_nettype none
// =============================================================================
// oam_dma_ctrl_if : CPU-side and DMA-side bus signals of the sprite OAM DMA.
// Revision: 1.0
// =============================================================================
interface oam_dma_ctrl_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic [7:0]  dma_din;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw;

  // master: the DMA controller, which takes over the bus while it runs
  modport master (
    input  cpu_ce, cpu_addr, cpu_dout, cpu_rw, dma_din,
    output cpu_rdy, dma_active, dma_addr, dma_dout, dma_rw
  );

  modport slave (
    output cpu_ce, cpu_addr, cpu_dout, cpu_rw, dma_din,
    input  cpu_rdy, dma_active, dma_addr, dma_dout, dma_rw
  );
endinterface
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// =============================================================================
// oam_dma_ctrl : halts the CPU and copies one 256-byte page to OAMDATA.
// Revision: 1.0
// =============================================================================
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic           clk,
  input  logic           n_reset,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_ALIGN     = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        parity_q, parity_d;
  logic        cpu_rdy_q, cpu_rdy_d;
  logic        dma_active_q, dma_active_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_dout_q, dma_dout_d;
  logic        dma_rw_q, dma_rw_d;

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    parity_d   = ~parity_q;
    dma_dout_d = dma_dout_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = bus.cpu_dout;
          idx_d   = 8'h00;
          state_d = ST_HALT_WAIT;
        end
      end
      ST_HALT_WAIT: begin
        // The 6502 only honours RDY on reads; the first read is the halt cycle.
        if (bus.cpu_rw) begin
          state_d = parity_q ? ST_READ : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        dma_dout_d = bus.dma_din;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // stable for the whole CPU cycle that state occupies.
    cpu_rdy_d    = (state_d == ST_IDLE);
    dma_active_d = (state_d == ST_READ) || (state_d == ST_WRITE);
    dma_rw_d     = (state_d != ST_WRITE);
    case (state_d)
      ST_READ:  dma_addr_d = {page_d, idx_d};
      ST_WRITE: dma_addr_d = OAMDATA_ADDR;
      default:  dma_addr_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      parity_q     <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_dout_q   <= 8'h00;
      dma_rw_q     <= 1'b1;
    end else if (bus.cpu_ce) begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      parity_q     <= parity_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
      dma_addr_q   <= dma_addr_d;
      dma_dout_q   <= dma_dout_d;
      dma_rw_q     <= dma_rw_d;
    end
  end

  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.dma_active = dma_active_q;
  assign bus.dma_addr   = dma_addr_q;
  assign bus.dma_dout   = dma_dout_q;
  assign bus.dma_rw     = dma_rw_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_oam_dma_ctrl : CPU/RAM model driving the OAM DMA with a write scoreboard.
// Revision: 1.0
// =============================================================================
module tb_oam_dma_ctrl;

  localparam logic [15:0] C_DMA_REG = 16'h4014;
  localparam logic [15:0] C_OAMDATA = 16'h2004;

  logic clk = 1'b0;
  logic n_reset;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: page $02 holds i ^ 8'h5A at offset i.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h58;
  endfunction

  assign bus.dma_din = mem_byte(bus.dma_addr);

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw;
    logic [2:0]  exp;   // {cpu_rdy, dma_active, dma_rw}
  } vec_t;

  xfer_t       sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          gap_mode = 1'b0;
  bit          par_m    = 1'b0;
  int          rdy_low, inact_low, writes_seen;
  logic [15:0] last_rd;
  bit          have_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [26:0] outs();
    return {bus.cpu_rdy, bus.dma_active, bus.dma_rw, bus.dma_addr, bus.dma_dout};
  endfunction

  // One CPU cycle: inputs set up, optional ce-free gap, then one cpu_ce edge.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    logic [26:0] snap;
    int          gap;
    gap = gap_mode ? 2 + int'($urandom_range(0, 2)) : 0;
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    bus.cpu_rw   = rw;
    bus.cpu_ce   = 1'b0;
    snap = outs();
    repeat (gap) @(negedge clk);
    if (gap > 0) check("hold_without_ce", 64'(outs()), 64'(snap));
    bus.cpu_ce = 1'b1;
    @(posedge clk);
    #1;
    par_m = ~par_m;
  endtask

  task automatic observe();
    xfer_t e;
    if (!bus.cpu_rdy) rdy_low++;
    if (!bus.cpu_rdy && !bus.dma_active) inact_low++;
    if (bus.dma_active && bus.dma_rw) begin
      last_rd = bus.dma_addr;
      have_rd = 1'b1;
    end else if (bus.dma_active && !bus.dma_rw) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("oam_write_%0d", writes_seen),
              {23'd0, have_rd, last_rd, bus.dma_addr, bus.dma_dout},
              {23'd0, 1'b1, e.addr, C_OAMDATA, e.data});
      end
      have_rd = 1'b0;
      writes_seen++;
    end
  endtask

  task automatic run_xfer(input logic [7:0] page, input int n_extra, input bit want_align,
                          input int mid_at, input int abort_at);
    int budget;
    if (par_m != want_align) begin
      cpu_cycle(16'h8000, 8'h00, 1'b1);
      check("idle_before_xfer", 64'({bus.cpu_rdy, bus.dma_active}), 64'(2'b10));
    end
    sb_q.delete();
    rdy_low = 0; inact_low = 0; writes_seen = 0; have_rd = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, i[7:0]};
      sb_q.push_back('{a, mem_byte(a)});
    end
    cpu_cycle(C_DMA_REG, page, 1'b0);
    observe();
    check("halt_wait_rdy", 64'({bus.cpu_rdy, bus.dma_active}), 64'(2'b00));
    for (int k = 0; k < n_extra; k++) begin
      cpu_cycle(16'h0100 + 16'(k), 8'hEE, 1'b0);
      observe();
      check("extra_write_hold", 64'({bus.cpu_rdy, bus.dma_active}), 64'(2'b00));
    end
    budget = 0;
    while (!bus.cpu_rdy && budget < 700) begin
      if (mid_at >= 0 && budget == mid_at) cpu_cycle(C_DMA_REG, 8'h55, 1'b0);
      else cpu_cycle(16'h8000, 8'h00, 1'b1);
      observe();
      budget++;
      if (abort_at >= 0 && writes_seen == abort_at + 1) return;
    end
    check("rdy_release_timeout", 64'(budget < 700), 64'd1);
    check("rdy_low_cycles", 64'(rdy_low), 64'(513 + int'(want_align) + n_extra));
    check("inactive_halt_cycles", 64'(inact_low), 64'(1 + int'(want_align) + n_extra));
    check("write_count", 64'(writes_seen), 64'd256);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h4015, 8'h07, 1'b0, 3'b101};
    vecs[1] = '{16'h4014, 8'h02, 1'b1, 3'b101};
    vecs[2] = '{16'h4013, 8'h02, 1'b0, 3'b101};
    vecs[3] = '{16'h2004, 8'h00, 1'b1, 3'b101};
    vecs[4] = '{16'hC014, 8'h02, 1'b0, 3'b101};
    vecs[5] = '{16'h4016, 8'h01, 1'b0, 3'b101};

    n_reset      = 1'b0;
    bus.cpu_ce   = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.cpu_rw   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'({1'b1, 1'b0, 1'b1, 16'h0000, 8'h00}));
    n_reset = 1'b1;
    par_m   = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cpu_cycle(vecs[i].addr, vecs[i].dout, vecs[i].rw);
      check($sformatf("idle_vec%0d", i),
            64'({bus.cpu_rdy, bus.dma_active, bus.dma_rw}), 64'(vecs[i].exp));
    end

    run_xfer(8'h02, 0, 1'b0, -1, -1);
    run_xfer(8'h02, 0, 1'b1, -1, -1);
    run_xfer(8'h03, 2, 1'b0, -1, -1);

    gap_mode = 1'b1;
    run_xfer(8'h02, 0, 1'b0, -1, -1);
    run_xfer(8'h02, 0, 1'b1, -1, -1);
    gap_mode = 1'b0;

    run_xfer(8'h02, 0, 1'b0, 100, -1);

    // Abort while the write of idx 8'h80 is on the bus.
    run_xfer(8'h02, 0, 1'b0, -1, 8'h80);
    check("abort_in_write", 64'({bus.dma_active, bus.dma_rw, bus.dma_addr}),
          64'({1'b1, 1'b0, C_OAMDATA}));
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({bus.cpu_rdy, bus.dma_active, bus.dma_rw, bus.dma_addr}),
          64'({1'b1, 1'b0, 1'b1, 16'h0000}));
    bus.cpu_ce = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    par_m   = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      cpu_cycle(16'h8000, 8'h00, 1'b1);
      check("idle_after_reset", 64'({bus.cpu_rdy, bus.dma_active}), 64'(2'b10));
    end
    run_xfer(8'h02, 0, 1'b0, -1, -1);

    run_xfer(8'hFF, 0, 1'b0, -1, -1);
    run_xfer(8'h20, 0, 1'b1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
